// File: rtl/ysyx_25010008_lsu.sv
// Load/store unit: runs one core memory request at a time as an AXI4-Lite read or write on arbiter port 1.
// Optional build macro LSU_MISALIGN_CHECK_EN answers misaligned half/word requests with an error and no bus beat.
module ysyx_25010008_lsu (
    input  logic        clock,
    input  logic        reset,
    // core request / response
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    // AXI4-Lite read channel
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    output logic        rready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    // AXI4-Lite write channel
    output logic [31:0] awaddr,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    output logic        bready,
    input  logic [1:0]  bresp,
    input  logic        bvalid
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RADDR = 3'd1;
    localparam logic [2:0] S_RDATA = 3'd2;
    localparam logic [2:0] S_WREQ  = 3'd3;
    localparam logic [2:0] S_WRESP = 3'd4;
    localparam logic [2:0] S_RESP  = 3'd5;

    logic [2:0]  state;
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic        aw_done;
    logic        w_done;

    logic        misaligned;
    logic [3:0]  strb_base;
    logic [31:0] lane;
    logic [31:0] load_ext;

    // NOTE: every handshake output is a decode of registered state, so no AXI input reaches an AXI output combinationally.
    assign req_ready  = (state == S_IDLE);
    assign arvalid    = (state == S_RADDR);
    assign rready     = (state == S_RDATA);
    assign awvalid    = (state == S_WREQ) && !aw_done;
    assign wvalid     = (state == S_WREQ) && !w_done;
    assign bready     = (state == S_WRESP);
    assign resp_valid = (state == S_RESP);

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        misaligned = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
        if (req_size == 2'd1)
            misaligned = req_addr[0];
        else if (req_size != 2'd0)
            misaligned = (req_addr[1:0] != 2'b00);
`endif
    end

    always_comb begin
        strb_base = 4'b1111;
        case (req_size)
            2'd0:    strb_base = 4'b0001;
            2'd1:    strb_base = 4'b0011;
            default: strb_base = 4'b1111;
        endcase
    end

    // Lanes shift by whole bytes, so a misaligned half/word simply loses the bytes past bit 31.
    always_comb begin
        lane     = rdata >> {off_q, 3'b000};
        load_ext = lane;
        case (size_q)
            2'd0:    load_ext = unsigned_q ? {24'b0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
            2'd1:    load_ext = unsigned_q ? {16'b0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
            default: load_ext = lane;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous to clock.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            off_q      <= 2'b00;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            araddr     <= 32'b0;
            awaddr     <= 32'b0;
            wdata      <= 32'b0;
            wstrb      <= 4'b0;
            resp_rdata <= 32'b0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        off_q      <= req_addr[1:0];
                        size_q     <= req_size;
                        unsigned_q <= req_unsigned;
                        aw_done    <= 1'b0;
                        w_done     <= 1'b0;
                        resp_rdata <= 32'b0;
                        resp_err   <= 1'b0;
                        if (misaligned) begin
                            resp_err <= 1'b1;
                            state    <= S_RESP;
                        end else if (req_wen) begin
                            awaddr <= {req_addr[31:2], 2'b00};
                            wdata  <= req_wdata << {req_addr[1:0], 3'b000};
                            wstrb  <= strb_base << req_addr[1:0];
                            state  <= S_WREQ;
                        end else begin
                            araddr <= {req_addr[31:2], 2'b00};
                            state  <= S_RADDR;
                        end
                    end
                end
                S_RADDR: begin
                    if (arready)
                        state <= S_RDATA;
                end
                S_RDATA: begin
                    if (rvalid) begin
                        resp_rdata <= load_ext;
                        resp_err   <= (rresp != 2'b00);
                        state      <= S_RESP;
                    end
                end
                S_WREQ: begin
                    // Address and data may complete in either order or in the same cycle.
                    if (awready)
                        aw_done <= 1'b1;
                    if (wready)
                        w_done <= 1'b1;
                    if ((aw_done || awready) && (w_done || wready))
                        state <= S_WRESP;
                end
                S_WRESP: begin
                    if (bvalid) begin
                        resp_err <= (bresp != 2'b00);
                        state    <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (resp_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_25010008_lsu.sv
// Self-checking bench for ysyx_25010008_lsu: directed requests against a byte-lane model of the LSU.
// Honours LSU_MISALIGN_CHECK_EN the same way the design does.
module tb_ysyx_25010008_lsu;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, req_wen = 1'b0, req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'b0, req_wdata = 32'b0;
    logic [1:0]  req_size = 2'b0;
    logic        req_ready, resp_valid, resp_err;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic [31:0] araddr, awaddr, wdata;
    logic        arvalid, rready, awvalid, wvalid, bready;
    logic        arready = 1'b0, rvalid = 1'b0, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
    logic [31:0] rdata = 32'b0;
    logic [1:0]  rresp = 2'b0, bresp = 2'b0;
    logic [3:0]  wstrb;

    ysyx_25010008_lsu dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .araddr(araddr), .arvalid(arvalid), .arready(arready), .rready(rready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready), .wdata(wdata), .wstrb(wstrb),
        .wvalid(wvalid), .wready(wready), .bready(bready), .bresp(bresp), .bvalid(bvalid)
    );

    always #5 clock = ~clock;

    localparam int BUDGET = 40;
`ifdef LSU_MISALIGN_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic misaligned_req(input logic [1:0] off, input logic [1:0] size);
        return CHECK_EN && ((int'(off) % nbytes(size)) != 0);
    endfunction

    function automatic logic [31:0] load_value(input logic [1:0] off, input logic [1:0] size,
                                               input logic uns, input logic [31:0] bus);
        int          n;
        logic [31:0] mask, v;
        n    = nbytes(size);
        mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
        v    = (bus >> (8 * int'(off))) & mask;
        if (!uns && n < 4 && v[8*n-1])
            v = v | ~mask;
        return v;
    endfunction

    logic        model_on = 1'b0;
    logic [31:0] exp_addr, exp_wdata, exp_rdata;
    logic [3:0]  exp_wstrb;
    logic        exp_err;

    // Continuous comparison of every meaningful DUT output against the model.
    always @(negedge clock) begin
        if (!reset && model_on) begin
            if (arvalid || awvalid)
                check_bit("ar_aw_exclusive", arvalid && awvalid, 1'b0);
            if (arvalid)
                check("araddr", araddr, exp_addr);
            if (awvalid)
                check("awaddr", awaddr, exp_addr);
            if (wvalid) begin
                check("wdata", wdata, exp_wdata);
                check("wstrb", 32'(wstrb), 32'(exp_wstrb));
            end
            if (resp_valid) begin
                check("resp_rdata", resp_rdata, exp_rdata);
                check_bit("resp_err", resp_err, exp_err);
                check_bit("req_ready_during_resp", req_ready, 1'b0);
            end
        end
    end

    // ---------------- stimulus tasks (called at posedge + 1) ----------------
    task automatic issue(input logic wen, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [1:0] size, input logic uns,
                         input logic [31:0] bus_data, input logic [1:0] bus_resp);
        int n;
        n         = nbytes(size);
        exp_addr  = {addr[31:2], 2'b00};
        exp_wdata = wd << (8 * int'(addr[1:0]));
        exp_wstrb = 4'(((1 << n) - 1) << int'(addr[1:0]));
        if (misaligned_req(addr[1:0], size)) begin
            exp_rdata = 32'b0;
            exp_err   = 1'b1;
        end else begin
            exp_rdata = wen ? 32'b0 : load_value(addr[1:0], size, uns, bus_data);
            exp_err   = (bus_resp != 2'b00);
        end
        model_on = 1'b1;
        check_bit("req_ready_idle", req_ready, 1'b1);
        req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wd;
        req_size = size; req_unsigned = uns;
        @(posedge clock); #1;
        // Scramble the request fields so only latched values can be used.
        req_valid = 1'b0; req_addr = ~addr; req_wdata = ~wd; req_size = ~size; req_unsigned = ~uns;
        check_bit("req_ready_busy", req_ready, 1'b0);
    endtask

    task automatic bus_load(input int ar_dly, input int r_dly, input logic [31:0] d, input logic [1:0] rr);
        int k;
        bit hs;
        k = 0; hs = 1'b0;
        while (!hs && k < BUDGET) begin
            check_bit("arvalid_held", arvalid, 1'b1);
            arready = (k >= ar_dly);
            hs = arvalid && arready;
            @(posedge clock); #1; k++;
        end
        arready = 1'b0;
        check_bit("ar_handshake_in_budget", hs, 1'b1);
        check_bit("arvalid_dropped", arvalid, 1'b0);
        k = 0; hs = 1'b0; rdata = d; rresp = rr;
        while (!hs && k < BUDGET) begin
            check_bit("rready_held", rready, 1'b1);
            rvalid = (k >= r_dly);
            hs = rvalid && rready;
            @(posedge clock); #1; k++;
        end
        rvalid = 1'b0; rdata = 32'hDEAD_BEEF; rresp = 2'b11;
        check_bit("r_handshake_in_budget", hs, 1'b1);
        check_bit("resp_after_rvalid", resp_valid, 1'b1);
        check_bit("rready_dropped", rready, 1'b0);
    endtask

    task automatic bus_store(input int aw_dly, input int w_dly, input int b_dly, input logic [1:0] br);
        int k;
        bit aw_d, w_d, aw_hs, w_hs, hs;
        k = 0; aw_d = 1'b0; w_d = 1'b0;
        while (!(aw_d && w_d) && k < BUDGET) begin
            check_bit("awvalid_level", awvalid, !aw_d);
            check_bit("wvalid_level", wvalid, !w_d);
            awready = (k >= aw_dly);
            wready  = (k >= w_dly);
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(posedge clock); #1; k++;
            aw_d = aw_d | aw_hs;
            w_d  = w_d | w_hs;
        end
        awready = 1'b0; wready = 1'b0;
        check_bit("aw_w_done_in_budget", aw_d && w_d, 1'b1);
        check_bit("awvalid_dropped", awvalid, 1'b0);
        check_bit("wvalid_dropped", wvalid, 1'b0);
        k = 0; hs = 1'b0; bresp = br;
        while (!hs && k < BUDGET) begin
            check_bit("bready_held", bready, 1'b1);
            check_bit("no_resp_before_b", resp_valid, 1'b0);
            bvalid = (k >= b_dly);
            hs = bvalid && bready;
            @(posedge clock); #1; k++;
        end
        bvalid = 1'b0; bresp = 2'b11;
        check_bit("b_handshake_in_budget", hs, 1'b1);
        check_bit("resp_after_bvalid", resp_valid, 1'b1);
    endtask

    task automatic finish_resp(input int hold);
        for (int h = 0; h < hold; h++) begin
            resp_ready = 1'b0;
            check_bit("resp_valid_held", resp_valid, 1'b1);
            @(posedge clock); #1;
        end
        resp_ready = 1'b1;
        @(posedge clock); #1;
        resp_ready = 1'b0;
        model_on   = 1'b0;
        check_bit("req_ready_after_resp", req_ready, 1'b1);
        check_bit("resp_valid_cleared", resp_valid, 1'b0);
    endtask

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] bus;
        logic [1:0]  rsp;
        int          d0, d1, d2;
    } vec_t;

    task automatic run_vec(input vec_t v);
        issue(v.wen, v.addr, v.wd, v.size, v.uns, v.bus, v.rsp);
        if (misaligned_req(v.addr[1:0], v.size)) begin
            check_bit("misaligned_no_arvalid", arvalid, 1'b0);
            check_bit("misaligned_no_awvalid", awvalid, 1'b0);
            check_bit("misaligned_resp_next", resp_valid, 1'b1);
        end else if (v.wen) begin
            bus_store(v.d0, v.d1, v.d2, v.rsp);
        end else begin
            bus_load(v.d0, v.d1, v.bus, v.rsp);
        end
        finish_resp(1);
    endtask

    vec_t vecs[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check_bit("rst_req_ready", req_ready, 1'b1);
        check_bit("rst_arvalid", arvalid, 1'b0);
        check_bit("rst_awvalid", awvalid, 1'b0);
        check_bit("rst_wvalid", wvalid, 1'b0);
        check_bit("rst_rready", rready, 1'b0);
        check_bit("rst_bready", bready, 1'b0);
        check_bit("rst_resp_valid", resp_valid, 1'b0);
        check_bit("rst_resp_err", resp_err, 1'b0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_araddr", araddr, 32'h0);
        check("rst_awaddr", awaddr, 32'h0);
        check("rst_wdata", wdata, 32'h0);
        check("rst_wstrb", 32'(wstrb), 32'h0);
        reset = 1'b0;

        // Word load, zero wait: response at T+3.
        issue(1'b0, 32'h8000_0004, 32'h0, 2'd2, 1'b0, 32'h1234_5678, 2'b00);
        check("lit_word_araddr", araddr, 32'h8000_0004);
        bus_load(0, 0, 32'h1234_5678, 2'b00);
        check("lit_word_rdata", resp_rdata, 32'h1234_5678);
        check_bit("lit_word_err", resp_err, 1'b0);
        finish_resp(0);

        // Signed and unsigned byte from lane 3.
        issue(1'b0, 32'h8000_0003, 32'h0, 2'd0, 1'b0, 32'h80FF_0000, 2'b00);
        bus_load(2, 1, 32'h80FF_0000, 2'b00);
        check("lit_sbyte_rdata", resp_rdata, 32'hFFFF_FF80);
        finish_resp(0);
        issue(1'b0, 32'h8000_0003, 32'h0, 2'd0, 1'b1, 32'h80FF_0000, 2'b00);
        bus_load(0, 2, 32'h80FF_0000, 2'b00);
        check("lit_ubyte_rdata", resp_rdata, 32'h0000_0080);
        finish_resp(0);

        // Halfword store, address accepted 3 cycles before data.
        issue(1'b1, 32'h8000_0002, 32'h0000_BEEF, 2'd1, 1'b0, 32'h0, 2'b00);
        check("lit_half_awaddr", awaddr, 32'h8000_0000);
        check("lit_half_wdata", wdata, 32'hBEEF_0000);
        check("lit_half_wstrb", 32'(wstrb), 32'h0000_000C);
        bus_store(0, 3, 2, 2'b00);
        check("lit_store_rdata", resp_rdata, 32'h0);
        finish_resp(0);

        // Word load with SLVERR, response held for 5 cycles.
        issue(1'b0, 32'h8000_0010, 32'h0, 2'd2, 1'b0, 32'hCAFE_F00D, 2'b10);
        bus_load(1, 0, 32'hCAFE_F00D, 2'b10);
        check_bit("lit_rresp_err", resp_err, 1'b1);
        finish_resp(5);

        // Misaligned word load.
        issue(1'b0, 32'h8000_0002, 32'h0, 2'd2, 1'b0, 32'hA1B2_C3D4, 2'b00);
`ifdef LSU_MISALIGN_CHECK_EN
        check_bit("lit_misalign_no_ar", arvalid, 1'b0);
        check_bit("lit_misalign_resp", resp_valid, 1'b1);
        check_bit("lit_misalign_err", resp_err, 1'b1);
`else
        check_bit("lit_misalign_ar", arvalid, 1'b1);
        check("lit_misalign_araddr", araddr, 32'h8000_0000);
        bus_load(0, 0, 32'hA1B2_C3D4, 2'b00);
`endif
        finish_resp(0);

        // Model-checked vectors: {wen, addr, wdata, size, uns, bus rdata, resp, d0, d1, d2}.
        vecs.push_back('{1'b0, 32'h8000_0102, 32'h0,         2'd1, 1'b0, 32'h8001_7FFF, 2'b00, 0, 0, 0});
        vecs.push_back('{1'b0, 32'h8000_0100, 32'h0,         2'd1, 1'b1, 32'h1234_F00D, 2'b00, 1, 3, 0});
        vecs.push_back('{1'b0, 32'h0200_0001, 32'h0,         2'd0, 1'b0, 32'h0000_7F00, 2'b00, 0, 0, 0});
        vecs.push_back('{1'b0, 32'h8000_0200, 32'h0,         2'd3, 1'b0, 32'h8765_4321, 2'b00, 2, 2, 0});
        vecs.push_back('{1'b0, 32'h8000_0203, 32'h0,         2'd1, 1'b0, 32'hF0AB_CDEF, 2'b00, 0, 0, 0});
        vecs.push_back('{1'b1, 32'h8000_0301, 32'h0000_00A5, 2'd0, 1'b0, 32'h0,         2'b00, 2, 0, 1});
        vecs.push_back('{1'b1, 32'h8000_0304, 32'h1122_3344, 2'd2, 1'b0, 32'h0,         2'b00, 0, 0, 0});
        vecs.push_back('{1'b1, 32'h8000_0308, 32'h5566_7788, 2'd2, 1'b0, 32'h0,         2'b10, 2, 2, 3});
        vecs.push_back('{1'b1, 32'h8000_0303, 32'h0000_1234, 2'd1, 1'b0, 32'h0,         2'b00, 1, 0, 0});
        vecs.push_back('{1'b1, 32'h8000_0301, 32'hDEAD_BEEF, 2'd2, 1'b0, 32'h0,         2'b01, 0, 1, 0});
        foreach (vecs[i])
            run_vec(vecs[i]);

        // Reset while waiting for read data, then a normal load.
        issue(1'b0, 32'h8000_0400, 32'h0, 2'd2, 1'b0, 32'h0, 2'b00);
        arready = 1'b1;
        @(posedge clock); #1;
        arready = 1'b0;
        check_bit("rdata_state_rready", rready, 1'b1);
        model_on = 1'b0;
        reset = 1'b1;
        @(posedge clock); #1;
        check_bit("mid_reset_rready", rready, 1'b0);
        check_bit("mid_reset_req_ready", req_ready, 1'b1);
        check_bit("mid_reset_resp_valid", resp_valid, 1'b0);
        reset = 1'b0;
        issue(1'b0, 32'h8000_0404, 32'h0, 2'd2, 1'b0, 32'h0BAD_CAFE, 2'b00);
        bus_load(0, 0, 32'h0BAD_CAFE, 2'b00);
        check("lit_post_reset_rdata", resp_rdata, 32'h0BAD_CAFE);
        finish_resp(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
